mem_arbiter: RTL

Two-port round-robin arbiter and access sequencer for the simulation memory (the `rom`-style word memory with combinational tri-state read and posedge write). It shares that memory between an instruction-fetch requester (port 0) and a data load/store requester (port 1). It also drives the memory's `addr`/`data`/`rd`/`wr`/`en` pins and returns registered read data with a one-cycle acknowledge pulse. It sits between the CPU core's fetch/LSU and the memory instance.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/rr_arbiter2.sv | 21 ++
 rtl/mem_arbiter.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // One-hot ack vector for a port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return (idx == PORT_DATA) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bus of the memory arbiter: fetch port 0 and data port 1.
interface mem_arbiter_if #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [1:0]            req;
  logic [1:0]            we;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [WORD_SIZE-1:0]  wdata0;
  logic [WORD_SIZE-1:0]  wdata1;
  logic [1:0]            ack;
  logic [WORD_SIZE-1:0]  rdata;

  modport master (
    output req, we, addr0, addr1, wdata0, wdata1,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr0, addr1, wdata0, wdata1,
    output ack, rdata
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick: on a tie the port that did not win last time wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_valid
);

  always_comb begin
    o_valid = |i_req;
    o_grant = PORT_FETCH;
    if (&i_req) begin
      o_grant = ~i_last_grant;
    end else if (i_req[1]) begin
      o_grant = PORT_DATA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter and access sequencer sharing one word memory between fetch and data ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDR_WIDTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  mem_arbiter_if.slave          io_bus,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0]  o_mem_data,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic                  o_mem_en,
  input  logic [WORD_SIZE-1:0]  i_mem_out
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_grant;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_SIZE-1:0]  r_wdata;
  logic [WORD_SIZE-1:0]  r_rdata;
  logic                  r_last_grant;

  logic                  w_grant;
  logic                  w_valid;
  logic                  w_latch;
  logic                  w_capture;
  logic                  w_release;
  logic [1:0]            w_ack;

  rr_arbiter2 u_rr (
    .i_req        (io_bus.req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_valid)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Outputs decode only registered state, so no request input reaches an output combinationally.
  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_release    = 1'b0;
    w_ack        = 2'b00;
    o_mem_en     = 1'b0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_addr   = '0;
    o_mem_data   = '0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_latch      = 1'b1;
          w_state_next = ACCESS;
        end
      end
      ACCESS: begin
        o_mem_en     = 1'b1;
        o_mem_rd     = ~r_we;
        o_mem_wr     = r_we;
        o_mem_addr   = r_addr;
        o_mem_data   = r_wdata;
        w_capture    = ~r_we;
        w_state_next = RESP;
      end
      RESP: begin
        w_ack        = port_onehot(r_grant);
        w_release    = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_grant      <= PORT_FETCH;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_last_grant <= PORT_DATA;
    end else begin
      if (w_latch) begin
        r_grant <= w_grant;
        r_we    <= (w_grant == PORT_DATA) ? io_bus.we[1]   : io_bus.we[0];
        r_addr  <= (w_grant == PORT_DATA) ? io_bus.addr1  : io_bus.addr0;
        r_wdata <= (w_grant == PORT_DATA) ? io_bus.wdata1 : io_bus.wdata0;
      end
      if (w_capture) begin
        r_rdata <= i_mem_out;
      end
      if (w_release) begin
        r_last_grant <= r_grant;
      end
    end
  end

  assign io_bus.ack   = w_ack;
  assign io_bus.rdata = r_rdata;

endmodule
